seq_decoder: RTL and testbench

- Registered, parametrised binary-to-one-hot decoder with a valid/ready input handshake and an auto-scan mode.
- Auto-scan steps the active output through a code range with a programmable dwell, e.g. for LED or digit multiplexing on the Tang Primer board.
- Sits between control logic and LED/segment drivers.
- Replaces the fixed 2-input / 3-output combinational decoder.

---
 rtl/seq_decoder.sv | 120 ++++++++++++
 tb/tb_seq_decoder.sv | 136 +++++++++++++
 2 files changed

// File: rtl/seq_decoder.sv
// seq_decoder: registered binary-to-one-hot decoder with a valid/ready input
// handshake and an auto-scan mode that steps the active output through
// 0..limit, holding each output for DWELL cycles.
// Optional build macro: SEQ_DECODER_ACTIVE_LOW_EN drives out_onehot one-cold
// (all ones when idle/reset/error) for active-low LEDs.
//
// state | meaning
// IDLE  | no code held, output cleared, accepting
// HOLD  | last direct-decode result held, accepting
// SCAN  | stepping through 0..limit, not accepting
module seq_decoder #(
  parameter int IN_W  = 2,
  parameter int OUT_W = 3,
  parameter int DWELL = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_code,
  input  logic             mode,
  output logic [OUT_W-1:0] out_onehot,
  output logic             out_valid,
  output logic             out_err
);

  localparam int              CW       = $clog2(DWELL + 1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(DWELL - 1);
  localparam logic [IN_W-1:0] CODE_MAX = IN_W'(OUT_W - 1);
`ifdef SEQ_DECODER_ACTIVE_LOW_EN
  localparam logic [OUT_W-1:0] POL = '1;
`else
  localparam logic [OUT_W-1:0] POL = '0;
`endif

  typedef enum logic [1:0] {IDLE, HOLD, SCAN} state_t;

  state_t           state, state_n;
  logic [IN_W-1:0]  idx, idx_n, lim, lim_n, idx_step;
  logic [CW-1:0]    cnt, cnt_n;
  logic [OUT_W-1:0] hot_cur, hot_n;
  logic             valid_n, err_n, accept, code_ok;

  assign in_ready = (state != SCAN);
  assign accept   = in_valid & in_ready;
  assign code_ok  = ({1'b0, in_code} < (IN_W + 1)'(OUT_W));
  // The output register holds the polarity-adjusted value; undo it to reason in active-high terms.
  assign hot_cur  = out_onehot ^ POL;

  // State and output registers; rst wins over everything, including a running scan.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= '0;
      lim        <= '0;
      cnt        <= '0;
      out_onehot <= POL;
      out_valid  <= 1'b0;
      out_err    <= 1'b0;
    end else begin
      state      <= state_n;
      idx        <= idx_n;
      lim        <= lim_n;
      cnt        <= cnt_n;
      out_onehot <= hot_n ^ POL;
      out_valid  <= valid_n;
      out_err    <= err_n;
    end
  end

  // Next-state, scan stepping and next output value.
  always_comb begin
    state_n  = state;
    idx_n    = idx;
    lim_n    = lim;
    cnt_n    = cnt;
    hot_n    = hot_cur;
    valid_n  = 1'b0;
    err_n    = 1'b0;
    idx_step = (idx == lim) ? '0 : idx + IN_W'(1);
    case (state)
      IDLE, HOLD: begin
        if (accept) begin
          valid_n = 1'b1;
          err_n   = ~code_ok;
          if (!mode) begin
            state_n = HOLD;
            hot_n   = code_ok ? (OUT_W'(1) << in_code) : '0;
          end else begin
            state_n = SCAN;
            lim_n   = code_ok ? in_code : CODE_MAX;
            idx_n   = '0;
            cnt_n   = '0;
            hot_n   = OUT_W'(1);
          end
        end
      end
      SCAN: begin
        if (cnt == CNT_LAST) begin
          cnt_n = '0;
          if (!mode) begin
            state_n = IDLE;
            idx_n   = '0;
            hot_n   = '0;
          end else begin
            idx_n = idx_step;
            hot_n = OUT_W'(1) << idx_step;
          end
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      default: begin
        state_n = IDLE;
        hot_n   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_seq_decoder.sv
// tb_seq_decoder: directed and random stimulus for seq_decoder (IN_W=2,
// OUT_W=3, DWELL=2) checked against a time-based reference model.
module tb_seq_decoder;

  localparam int IN_W  = 2;
  localparam int OUT_W = 3;
  localparam int DWELL = 2;
`ifdef SEQ_DECODER_ACTIVE_LOW_EN
  localparam logic [OUT_W-1:0] POL = 3'b111;
`else
  localparam logic [OUT_W-1:0] POL = 3'b000;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [IN_W-1:0]  in_code = '0;
  logic             mode = 1'b0;
  logic [OUT_W-1:0] out_onehot;
  logic             out_valid;
  logic             out_err;

  int errors = 0;
  int checks = 0;

  // reference model: scan output index derived from elapsed cycles since entry
  bit m_scan = 1'b0;
  int m_t    = 0;
  int m_lim  = 0;
  int m_hot  = 0;
  bit m_valid = 1'b0;
  bit m_err   = 1'b0;

  seq_decoder #(.IN_W(IN_W), .OUT_W(OUT_W), .DWELL(DWELL)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_code(in_code), .mode(mode), .out_onehot(out_onehot),
    .out_valid(out_valid), .out_err(out_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got=%b expected=%b", tag, got, exp);
    end
  endtask

  task automatic model_step(input bit r, input bit v, input int code, input bit md);
    m_valid = 1'b0;
    m_err   = 1'b0;
    if (r) begin
      m_scan = 1'b0; m_hot = 0; m_t = 0;
    end else if (m_scan) begin
      if ((m_t % DWELL) == DWELL - 1 && !md) begin
        m_scan = 1'b0; m_hot = 0;
      end else begin
        m_t++;
        m_hot = 1 << ((m_t / DWELL) % (m_lim + 1));
      end
    end else if (v) begin
      m_valid = 1'b1;
      m_err   = (code >= OUT_W);
      if (!md) begin
        m_hot = (code < OUT_W) ? (1 << code) : 0;
      end else begin
        m_scan = 1'b1; m_t = 0; m_hot = 1;
        m_lim  = (code < OUT_W) ? code : OUT_W - 1;
      end
    end
  endtask

  task automatic tick(input bit r, input bit v, input int code, input bit md);
    logic [OUT_W-1:0] exp_out;
    rst = r; in_valid = v; in_code = IN_W'(code); mode = md;
    model_step(r, v, code, md);
    @(posedge clk);
    #1;
    exp_out = OUT_W'(m_hot) ^ POL;
    check("out_onehot", 8'(out_onehot), 8'(exp_out));
    check("out_valid",  8'(out_valid),  8'(m_valid));
    check("out_err",    8'(out_err),    8'(m_err));
    check("in_ready",   8'(in_ready),   8'(!m_scan));
    check("single_hot", 8'($countones(out_onehot ^ POL) <= 1), 8'd1);
  endtask

  initial begin
    // reset for two cycles
    tick(1, 0, 0, 0);
    tick(1, 0, 0, 0);
    check("reset_literal", 8'(out_onehot), 8'(3'b000 ^ POL));
    tick(0, 0, 0, 0);

    // direct decode 0,1,2 back to back, then error code 3
    tick(0, 1, 0, 0);
    tick(0, 1, 1, 0);
    check("code1_literal", 8'(out_onehot), 8'(3'b010 ^ POL));
    tick(0, 1, 2, 0);
    tick(0, 1, 3, 0);
    tick(0, 0, 0, 0);
    tick(0, 0, 0, 0);

    // scan to limit 2, wrap around, then drop mode and exit at a step boundary
    tick(0, 1, 2, 1);
    for (int i = 0; i < 9; i++) tick(0, i[0], 1, 1);
    for (int i = 0; i < 3; i++) tick(0, 0, 0, 0);

    // scan with out-of-range code 3 (clamped), drop mode mid-dwell
    tick(0, 1, 3, 1);
    for (int i = 0; i < 4; i++) tick(0, 0, 0, 1);
    tick(0, 0, 0, 0);
    tick(0, 0, 0, 0);
    tick(0, 0, 0, 0);

    // scan with limit 0 keeps output 0 active
    tick(0, 1, 0, 1);
    for (int i = 0; i < 5; i++) tick(0, 0, 0, 1);

    // reset mid-scan
    tick(1, 0, 0, 1);
    check("rst_scan_literal", 8'(out_onehot), 8'(3'b000 ^ POL));
    tick(0, 0, 0, 0);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      tick(($urandom_range(0, 59) == 0), ($urandom_range(0, 2) != 0),
           int'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
